// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes: streams instruction words into one fixed-size slot of instruction memory.
// Define CARREGADOR_CHECKSUM_EN to require a trailing checksum word before completion.
module carregador_instrucoes #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SLOT_SIZE = 200,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_BITS = 3,
  parameter int COUNT_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SLOT_BITS-1:0]  slot,
  input  logic [COUNT_BITS-1:0] word_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_endereco,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  erro
);
`ifdef CARREGADOR_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, FIM} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, FIM} state_t;
`endif
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [COUNT_BITS-1:0] offset, remaining;
  logic start_ok, accept, xfer, last, sum_bad;
  assign start_ok = 32'(slot) < NUM_SLOTS && word_count != '0 && 32'(word_count) <= SLOT_SIZE;
  assign accept = state == IDLE && start && start_ok;
  assign xfer = in_valid && in_ready;
  assign last = remaining == COUNT_BITS'(1);
`ifdef CARREGADOR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  assign sum_bad = state == CHECK && xfer && in_data != sum;
  always_ff @(posedge clock) begin
    if (reset) sum <= '0;
    else if (accept) sum <= '0;
    else if (state == LOAD && xfer) sum <= sum + in_data;
  end
`else
  assign sum_bad = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = accept ? LOAD : IDLE;
`ifdef CARREGADOR_CHECKSUM_EN
      LOAD: state_next = xfer && last ? CHECK : LOAD;
      CHECK: state_next = xfer ? (sum_bad ? IDLE : FIM) : CHECK;
`else
      LOAD: state_next = xfer && last ? FIM : LOAD;
`endif
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
`ifdef CARREGADOR_CHECKSUM_EN
    in_ready = state == LOAD || state == CHECK;
`else
    in_ready = state == LOAD;
`endif
    busy = in_ready;
    done = state == FIM;
  end
  // Writes are registered: address and data appear the cycle after acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we <= 1'b0;
      mem_endereco <= '0;
      mem_data <= '0;
      erro <= 1'b0;
      base <= '0;
      offset <= '0;
      remaining <= '0;
    end else begin
      mem_we <= state == LOAD && xfer;
      erro <= (state == IDLE && start && !start_ok) || sum_bad;
      if (accept) begin
        base <= ADDR_WIDTH'(slot) * ADDR_WIDTH'(SLOT_SIZE);
        remaining <= word_count;
        offset <= '0;
      end
      if (state == LOAD && xfer) begin
        mem_endereco <= base + ADDR_WIDTH'(offset);
        mem_data <= in_data;
        offset <= offset + COUNT_BITS'(1);
        remaining <= remaining - COUNT_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb_carregador_instrucoes: randomized loads checked by a write scoreboard and handshake/pulse checks.
module tb_carregador_instrucoes;
  logic clock, reset, start, in_valid, in_ready, mem_we, busy, done, erro;
  logic [2:0] slot;
  logic [7:0] word_count;
  logic [31:0] in_data, mem_endereco, mem_data;
  int checks = 0, errors = 0, done_cnt = 0, erro_cnt = 0;
  logic [31:0] exp_addr[$], exp_data[$];

  carregador_instrucoes dut (
    .clock(clock), .reset(reset), .start(start), .slot(slot), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_endereco(mem_endereco), .mem_data(mem_data), .busy(busy), .done(done), .erro(erro)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the oldest expected write.
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (erro) erro_cnt++;
    if (mem_we) begin
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected", mem_endereco, mem_data);
      end else begin
        logic [31:0] ea, ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (mem_endereco !== ea || mem_data !== ed) begin
          errors++;
          $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h", mem_endereco, mem_data, ea, ed);
        end
      end
    end
  end

  // Expected address of word i in slot s is s*200+i; a start is valid for s<4 and 1<=c<=200.
  task automatic load(input int s, input int c, input bit stall, input bit noise, input int fixed_base, input bit bad_sum);
    int sent, budget, d0, e0;
    bit ok, v;
    logic [31:0] w;
`ifdef CARREGADOR_CHECKSUM_EN
    logic [31:0] sum;
    sum = 0;
`endif
    sent = 0;
    budget = 0;
    d0 = done_cnt;
    e0 = erro_cnt;
    ok = s < 4 && c >= 1 && c <= 200;
    start = 1;
    slot = 3'(s);
    word_count = 8'(c);
    @(negedge clock);
    start = 0;
    if (!ok) begin
      check("reject_erro_pulse", erro, 1);
      check("reject_busy", busy, 0);
      check("reject_ready", in_ready, 0);
      @(negedge clock);
      check("reject_erro_count", erro_cnt - e0, 1);
      check("reject_done_count", done_cnt - d0, 0);
      return;
    end
    while (sent < c && budget < 5000) begin
      check("load_busy", busy, 1);
      check("load_ready", in_ready, 1);
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w = fixed_base >= 0 ? 32'(fixed_base + sent) : $urandom;
      in_valid = v;
      in_data = w;
      start = noise && $urandom_range(0, 3) == 0;
      slot = 3'd7;
      word_count = 8'd0;
      if (v) begin
        exp_addr.push_back(32'(s * 200 + sent));
        exp_data.push_back(w);
`ifdef CARREGADOR_CHECKSUM_EN
        sum += w;
`endif
        sent++;
      end
      @(negedge clock);
      budget++;
    end
    in_valid = 0;
    start = 0;
    in_data = $urandom;
    check("load_words_sent", sent, c);
`ifdef CARREGADOR_CHECKSUM_EN
    check("check_ready", in_ready, 1);
    in_valid = 1;
    in_data = bad_sum ? sum + 1 : sum;
    @(negedge clock);
    in_valid = 0;
    in_data = $urandom;
    @(negedge clock);
`else
    check("fim_done", done, 1);
    check("fim_busy", busy, 0);
    @(negedge clock);
    check("idle_done", done, 0);
`endif
    check("done_count", done_cnt - d0, bad_sum ? 0 : 1);
    check("erro_count", erro_cnt - e0, bad_sum ? 1 : 0);
  endtask

  initial begin
    reset = 1;
    start = 0;
    slot = 0;
    word_count = 0;
    in_valid = 0;
    in_data = 0;
    repeat (3) @(negedge clock);
    check("reset_mem_we", mem_we, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_erro", erro, 0);
    check("reset_ready", in_ready, 0);
    check("reset_addr", mem_endereco, 0);
    reset = 0;
    @(negedge clock);
    load(2, 3, 0, 0, 'hA, 0);
    load(1, 2, 1, 0, -1, 0);
    load(4, 1, 0, 0, -1, 0);
    load(0, 0, 0, 0, -1, 0);
    load(0, 201, 0, 0, -1, 0);
    load(3, 200, 0, 0, -1, 0);
    start = 1;
    slot = 0;
    word_count = 5;
    @(negedge clock);
    start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1;
      in_data = $urandom;
      exp_addr.push_back(32'(i));
      exp_data.push_back(in_data);
      @(negedge clock);
    end
    in_valid = 0;
    reset = 1;
    @(negedge clock);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_erro", erro, 0);
    check("midrst_addr", mem_endereco, 0);
    reset = 0;
    @(negedge clock);
    load(0, 1, 0, 0, -1, 0);
    for (int i = 0; i < 6; i++) load($urandom_range(0, 3), $urandom_range(1, 12), 1, 1, -1, 0);
`ifdef CARREGADOR_CHECKSUM_EN
    load(0, 2, 0, 0, 1, 0);
    load(0, 2, 0, 0, 1, 1);
`endif
    repeat (2) @(negedge clock);
    check("queue_empty", exp_addr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/carregador_instrucoes.md
Name: carregador_instrucoes

Overview:
- Write-side loader for the instruction memory.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into one fixed-size program slot of instruction memory.
- Slot 0 is the context-switch routine, slot 1 the OS, slots 2+ user programs.
- Sits between the host/boot link and the instruction RAM write port; the read side (fetch) is unaffected.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, memory address width.
- SLOT_SIZE, 200, words per program slot.
- NUM_SLOTS, 4, number of slots; valid slot indices are 0..NUM_SLOTS-1.
- SLOT_BITS, 3, width of the slot index input.
- COUNT_BITS, 8, width of the word count input; must hold SLOT_SIZE.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- slot  in  SLOT_BITS  target slot index, latched on start.
- word_count  in  COUNT_BITS  number of instruction words to load, latched on start.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_WIDTH  stream word.
- in_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  instruction memory write enable.
- mem_endereco  out  ADDR_WIDTH  write address.
- mem_data  out  DATA_WIDTH  write data.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- erro  out  1  one-cycle pulse on a rejected start or failed load.

Behaviour:
- Reset values: all outputs 0, state IDLE, base/offset/count registers 0.
- States: IDLE, LOAD, CHECK (present only with the optional feature), FIM.
- IDLE:
  - in_ready=0.
  - On start, if slot>=NUM_SLOTS, word_count==0, or word_count>SLOT_SIZE: erro pulses the next cycle and the state stays IDLE.
  - Otherwise: latch base=slot*SLOT_SIZE (unsigned, zero-extended to ADDR_WIDTH), remaining=word_count, offset=0; go to LOAD.
- LOAD:
  - in_ready=1 combinationally while in LOAD.
  - A transfer occurs when in_valid&&in_ready.
  - On a transfer: the next cycle shows mem_we=1, mem_endereco=base+offset, mem_data=in_data. offset increments and remaining decrements.
  - Write latency: exactly 1 cycle from transfer to mem_we.
  - in_valid low: no write, no state change.
  - When the transfer that brings remaining to 0 occurs, go to FIM (or CHECK when the feature is enabled).
  - Address never leaves [base, base+word_count-1], so slot boundaries are never crossed.
- FIM: done=1 for exactly one cycle, busy drops the same cycle, next state IDLE. mem_we is 0 unless it is the registered write of the last word, which coincides with the FIM cycle.
- start asserted outside IDLE is ignored: no erro, no re-latch.
- Back-to-back loads: start may be asserted in the first IDLE cycle after FIM.
- Reset mid-load: immediate return to IDLE with all outputs 0 the next cycle. A write already registered is dropped (mem_we=0). Partially written memory contents are left as-is.
- in_data is ignored whenever in_ready=0.

Optional Feature:
- Macro CARREGADOR_CHECKSUM_EN.
- Enabled:
  - The loader keeps a DATA_WIDTH modulo-2^DATA_WIDTH sum of all written words.
  - After the last instruction, enter CHECK with in_ready=1. The next transferred word is a checksum and is not written to memory.
  - Equal to the sum: go to FIM (done pulse). Mismatch: erro pulses one cycle and return to IDLE (no done).
- Disabled: no CHECK state, no accumulator; the load completes after word_count words.

Test Plan:
- Nominal: start slot=2, word_count=3, words 0xA,0xB,0xC with in_valid held high -> writes at 400,401,402 on consecutive cycles, each one cycle after acceptance; done pulses once; busy high throughout the load.
- Stall: slot=1, count=2, in_valid toggling 1,0,0,1 -> exactly two mem_we pulses at addresses 200 and 201; nothing written during the gaps.
- Rejects: start with slot=4; start with count=0; start with count=201 -> erro pulse each time, busy stays 0, no mem_we.
- Boundary: slot=3, count=200 -> last write at address 799; done pulses; no address 800 is ever written.
- Reset mid-load: slot=0, count=5, reset after 2 transfers -> addresses 0 and 1 written, outputs 0 the next cycle; a following start slot=0, count=1 loads address 0 normally.
- Checksum (macro on): count=2, words 1,2, then checksum 3 -> done pulses. Repeat with checksum 4 -> erro pulses, no done, and the checksum word is never written.
